mouse_sprite_ctrl: RTL and testbench

//  Controls the 32x32 mouse-pointer sprite RAM (1-cycle registered read, separate write port).
//  - Decodes CPU slot writes into position/control registers or sprite-RAM writes.
//  - Generates RAM read addresses from the scan position and keys the pointer over the incoming video stream.
//  - Position is double-buffered and updated only at frame start, so the pointer never tears mid-frame.

---
 rtl/mouse_pkg.sv | 15 +
 rtl/mouse_hit_calc.sv | 32 +++
 rtl/mouse_sprite_ctrl.sv | 100 ++++++++++
 tb/tb_mouse_sprite_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared register map and control-word layout for the mouse-pointer sprite controller.
package mouse_pkg;

    localparam int SPR_SEL = 10;

    localparam logic [1:0] REG_XPOS = 2'd0;
    localparam logic [1:0] REG_YPOS = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    typedef struct packed {
        logic        en;
        logic [11:0] key;
    } mouse_ctrl_t;

endpackage

// File: rtl/mouse_hit_calc.sv
// Stage-0 hit test and sprite RAM read address generation.
// Optional 2x pointer scaling is selected with the MOUSE_SCALE2X_EN macro.
module mouse_hit_calc #(
    parameter int SPR_BITS = 5
) (
    input  logic [10:0]           x,
    input  logic [10:0]           y,
    input  logic [10:0]           xa,
    input  logic [10:0]           ya,
    input  logic                  en,
    output logic                  hit,
    output logic [2*SPR_BITS-1:0] ram_addr_r
);

    logic [10:0] dx;
    logic [10:0] dy;

    assign dx = x - xa;
    assign dy = y - ya;

`ifdef MOUSE_SCALE2X_EN
    localparam logic [10:0] LIMIT = 11'(1 << (SPR_BITS + 1));
    assign ram_addr_r = {dy[SPR_BITS:1], dx[SPR_BITS:1]};
`else
    localparam logic [10:0] LIMIT = 11'(1 << SPR_BITS);
    assign ram_addr_r = {dy[SPR_BITS-1:0], dx[SPR_BITS-1:0]};
`endif

    // The x>=xa / y>=ya terms stop a wrapped subtraction from hitting: no wrap at the screen edge.
    assign hit = en & (x >= xa) & (y >= ya) & (dx < LIMIT) & (dy < LIMIT);

endmodule

// File: rtl/mouse_sprite_ctrl.sv
// Mouse-pointer sprite controller: CPU slot registers, frame-synchronous position update and
// 2-stage chroma-keyed overlay. Define MOUSE_SCALE2X_EN for a 2x scaled pointer.
module mouse_sprite_ctrl
    import mouse_pkg::*;
#(
    parameter int              CD       = 12,
    parameter int              SPR_BITS = 5,
    parameter logic [CD-1:0]   KEY_RST  = 12'h000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  write,
    input  logic [10:0]           addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    input  logic                  frame_start,
    input  logic [10:0]           x,
    input  logic [10:0]           y,
    input  logic [CD-1:0]         si_rgb,
    output logic [CD-1:0]         so_rgb,
    output logic                  ram_we,
    output logic [2*SPR_BITS-1:0] ram_addr_w,
    output logic [CD-1:0]         ram_din,
    output logic [2*SPR_BITS-1:0] ram_addr_r,
    input  logic [CD-1:0]         ram_dout
);

    logic [10:0]  x_pend, y_pend, x_act, y_act;
    mouse_ctrl_t  ctrl_q;
    logic         reg_we, wr_x, wr_y, wr_ctrl;
    logic         hit, hit_d1;
    logic [CD-1:0] si_d1;
    logic         unused_wr_bits;

    assign reg_we  = cs & write & ~addr[SPR_SEL];
    assign wr_x    = reg_we & (addr[1:0] == REG_XPOS);
    assign wr_y    = reg_we & (addr[1:0] == REG_YPOS);
    assign wr_ctrl = reg_we & (addr[1:0] == REG_CTRL);

    assign ram_we     = cs & write & addr[SPR_SEL];
    assign ram_addr_w = addr[2*SPR_BITS-1:0];
    assign ram_din    = wr_data[CD-1:0];

    assign unused_wr_bits = ^wr_data[31:CD+1];

    always_comb begin
        rd_data = '0;
        if (!addr[SPR_SEL]) begin
            case (addr[1:0])
                REG_XPOS: rd_data[10:0] = x_pend;
                REG_YPOS: rd_data[10:0] = y_pend;
                REG_CTRL: rd_data[CD:0] = {ctrl_q.key, ctrl_q.en};
                default:  rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_pend <= '0;
            y_pend <= '0;
            x_act  <= '0;
            y_act  <= '0;
            ctrl_q <= '{en: 1'b0, key: KEY_RST};
        end else begin
            if (wr_x) x_pend <= wr_data[10:0];
            if (wr_y) y_pend <= wr_data[10:0];
            // A position write landing on frame_start is forwarded so it applies to this frame.
            if (frame_start) begin
                x_act <= wr_x ? wr_data[10:0] : x_pend;
                y_act <= wr_y ? wr_data[10:0] : y_pend;
            end
            if (wr_ctrl) ctrl_q <= '{en: wr_data[0], key: wr_data[CD:1]};
        end
    end

    mouse_hit_calc #(.SPR_BITS(SPR_BITS)) u_hit (
        .x          (x),
        .y          (y),
        .xa         (x_act),
        .ya         (y_act),
        .en         (ctrl_q.en),
        .hit        (hit),
        .ram_addr_r (ram_addr_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_d1 <= 1'b0;
            si_d1  <= '0;
            so_rgb <= '0;
        end else begin
            hit_d1 <= hit;
            si_d1  <= si_rgb;
            so_rgb <= (hit_d1 && (ram_dout != ctrl_q.key)) ? ram_dout : si_d1;
        end
    end

endmodule

// File: tb/tb_mouse_sprite_ctrl.sv
// Directed bench for mouse_sprite_ctrl with a 1-cycle registered sprite RAM model.
// Honours MOUSE_SCALE2X_EN for the scaled-pointer expectations.
module tb_mouse_sprite_ctrl;

`ifdef MOUSE_SCALE2X_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, write, frame_start;
    logic [10:0] addr, x, y;
    logic [31:0] wr_data, rd_data;
    logic [11:0] si_rgb, so_rgb, ram_din, ram_dout;
    logic        ram_we;
    logic [9:0]  ram_addr_w, ram_addr_r;
    logic [11:0] mem [1024];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mouse_sprite_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cs          (cs),
        .write       (write),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .frame_start (frame_start),
        .x           (x),
        .y           (y),
        .si_rgb      (si_rgb),
        .so_rgb      (so_rgb),
        .ram_we      (ram_we),
        .ram_addr_w  (ram_addr_w),
        .ram_din     (ram_din),
        .ram_addr_r  (ram_addr_r),
        .ram_dout    (ram_dout)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr_w] <= ram_din;
        ram_dout <= mem[ram_addr_r];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic fs);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d; frame_start = fs;
        tick;
        cs = 1'b0; write = 1'b0; frame_start = 1'b0; addr = '0;
    endtask

    task automatic fs_pulse;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    task automatic pix(input string tag, input logic [10:0] px, input logic [10:0] py,
                       input logic [11:0] exp);
        x = px; y = py; si_rgb = 12'h0F0;
        tick;
        tick;
        chk(tag, {20'h0, so_rgb}, {20'h0, exp});
    endtask

    task automatic rd(input string tag, input logic [10:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        reset = 1'b1; cs = 1'b0; write = 1'b0; frame_start = 1'b0;
        addr = '0; wr_data = '0; x = '0; y = '0; si_rgb = 12'h0F0;
        repeat (3) tick;
        chk("rst_so", {20'h0, so_rgb}, 32'h0);
        si_rgb = '0;
        tick;
        reset = 1'b0;
        rd("rst_x", 11'd0, 32'd0);
        rd("rst_y", 11'd1, 32'd0);
        rd("rst_ctrl", 11'd2, 32'd0);

        // latency: so_rgb after edge i carries the value set before edge i-1
        for (int i = 0; i < 6; i++) begin
            si_rgb = 12'h0F0 + 12'(i);
            x = 11'(i);
            tick;
            chk("latency", {20'h0, so_rgb}, (i == 0) ? 32'h0 : 32'h0F0 + 32'(i - 1));
        end
        pix("sweep0", 11'd0, 11'd0, 12'h0F0);
        pix("sweep1", 11'd639, 11'd479, 12'h0F0);

        // test 2
        wr(11'h400, 32'hF00, 1'b0);
        wr(11'h7FF, 32'h123, 1'b0);
        wr(11'd0, 32'd100, 1'b0);
        wr(11'd1, 32'd50, 1'b0);
        wr(11'd2, 32'h1, 1'b0);
        rd("rd_x", 11'd0, 32'd100);
        rd("rd_y", 11'd1, 32'd50);
        rd("rd_ctrl", 11'd2, 32'h1);
        rd("rd_rsvd", 11'd3, 32'h0);
        rd("rd_ram", 11'h400, 32'h0);
        fs_pulse;
        pix("hit_100_50", 11'd100, 11'd50, 12'hF00);
        pix("left_99_50", 11'd99, 11'd50, 12'h0F0);
        pix("right_132_50", 11'd132, 11'd50, 12'h0F0);
        pix("corner_131_81", 11'd131, 11'd81, SC ? 12'h0F0 : 12'h123);
        pix("below_100_82", 11'd100, 11'd82, 12'h0F0);

        // test 3
        wr(11'd0, 32'd200, 1'b0);
        rd("rd_x_pend", 11'd0, 32'd200);
        pix("no_tear", 11'd100, 11'd50, 12'hF00);
        fs_pulse;
        pix("moved_200", 11'd200, 11'd50, 12'hF00);
        pix("old_100", 11'd100, 11'd50, 12'h0F0);
        wr(11'd0, 32'd300, 1'b1);
        pix("fwd_300", 11'd300, 11'd50, 12'hF00);

        // test 4
        wr(11'h409, 32'h456, 1'b0);
        wr(11'd0, 32'd630, 1'b1);
        pix("edge_630", 11'd630, 11'd50, 12'hF00);
        pix("edge_639", 11'd639, 11'd50, SC ? 12'h0F0 : 12'h456);
        pix("nowrap_0_50", 11'd0, 11'd50, 12'h0F0);
        pix("nowrap_0_51", 11'd0, 11'd51, 12'h0F0);

        // test 5: key = F00, enabled
        wr(11'd2, 32'h1E01, 1'b0);
        rd("rd_ctrl_key", 11'd2, 32'h1E01);
        pix("keyed_630", 11'd630, 11'd50, 12'h0F0);
        pix("opaque_639", 11'd639, 11'd50, SC ? 12'h000 : 12'h456);

        x = 11'd630; y = 11'd50;
        cs = 1'b1; write = 1'b1; addr = 11'h455; wr_data = 32'hFFFF_F7A5; #1;
        chk("ram_we", {31'h0, ram_we}, 32'h1);
        chk("ram_addr_w", {22'h0, ram_addr_w}, 32'h055);
        chk("ram_din", {20'h0, ram_din}, 32'h7A5);
        addr = 11'h002; #1;
        chk("ram_we_reg", {31'h0, ram_we}, 32'h0);
        cs = 1'b0; write = 1'b0; addr = '0;

        wr(11'd2, 32'h0, 1'b0);
        pix("disabled", 11'd630, 11'd50, 12'h0F0);

        // reset mid-frame
        wr(11'd2, 32'h1, 1'b0);
        pix("reenabled", 11'd630, 11'd50, 12'hF00);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        rd("mid_rst_ctrl", 11'd2, 32'h0);
        rd("mid_rst_x", 11'd0, 32'h0);
        pix("mid_rst_pass", 11'd0, 11'd0, 12'h0F0);

        // test 6
        wr(11'h401, 32'hABC, 1'b0);
        wr(11'd2, 32'h1, 1'b0);
        fs_pulse;
        pix("sc_2_0", 11'd2, 11'd0, SC ? 12'hABC : 12'h0F0);
        pix("sc_3_0", 11'd3, 11'd0, SC ? 12'hABC : 12'h0F0);
        pix("sc_2_1", 11'd2, 11'd1, SC ? 12'hABC : 12'h0F0);
        pix("sc_3_1", 11'd3, 11'd1, SC ? 12'hABC : 12'h0F0);
        pix("sc_1_0", 11'd1, 11'd0, SC ? 12'hF00 : 12'hABC);
        pix("sc_4_0", 11'd4, 11'd0, 12'h0F0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
